// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
//   Shares one single-ported synchronous data memory between two caches.
//   One request is latched at a time. The memory is strobed in the first
//   ACCESS cycle and the FSM then waits LAT cycles in ACCESS in total. A
//   one-cycle completion pulse follows, and the FSM then holds until the
//   served cache drops its request. Ties are broken round-robin.
//
//   Optional feature macro: MEMARB_WRITE_PRIORITY_EN
//     When defined, a tie where exactly one port requests WRITE goes to the
//     writer. Otherwise, and for ties of equal kind, round-robin applies.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   rwFromCacheA/B   [RW_W]          request code (01 READ, 10 WRITE, else idle)
//   addrFromCacheA/B [ADDR_W]        request address
//   dataFromCacheA/B [DATA_W]        write data
//   dataToCacheA/B   [DATA_W]        registered read data
//   rdEnToCacheA/B                   one-cycle read-complete pulse
//   wbDoneToCacheA/B                 one-cycle write-complete pulse
//   memEn, memWe                     memory strobe / write enable
//   memAddr, memWdata                memory address / write data
//   memRdata         [DATA_W]        memory read data
//   grantB                           current or last grant (0 = A, 1 = B)
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RW_W   = 2,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RW_W-1:0]   rwFromCacheA,
    input  logic [RW_W-1:0]   rwFromCacheB,
    input  logic [ADDR_W-1:0] addrFromCacheA,
    input  logic [ADDR_W-1:0] addrFromCacheB,
    input  logic [DATA_W-1:0] dataFromCacheA,
    input  logic [DATA_W-1:0] dataFromCacheB,
    output logic [DATA_W-1:0] dataToCacheA,
    output logic [DATA_W-1:0] dataToCacheB,
    output logic              rdEnToCacheA,
    output logic              rdEnToCacheB,
    output logic              wbDoneToCacheA,
    output logic              wbDoneToCacheB,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    output logic              grantB
);

    localparam logic [RW_W-1:0] RW_READ  = RW_W'(1);
    localparam logic [RW_W-1:0] RW_WRITE = RW_W'(2);
    localparam logic [3:0]      CNT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                last_grant;
    logic                grant_b;
    logic                op_wr;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                req_a;
    logic                req_b;
    logic                wr_a;
    logic                wr_b;
    logic                pick_b;

    // Code 2'b11 (and anything else unknown) counts as idle.
    assign wr_a  = (rwFromCacheA == RW_WRITE);
    assign wr_b  = (rwFromCacheB == RW_WRITE);
    assign req_a = (rwFromCacheA == RW_READ) || wr_a;
    assign req_b = (rwFromCacheB == RW_READ) || wr_b;

    always_comb begin
        pick_b = req_b;
        if (req_a && req_b) begin
            pick_b = ~last_grant;
`ifdef MEMARB_WRITE_PRIORITY_EN
            if (wr_a != wr_b) begin
                pick_b = wr_b;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            last_grant   <= 1'b1;
            grant_b      <= 1'b0;
            op_wr        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dataToCacheA <= '0;
            dataToCacheB <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        grant_b <= pick_b;
                        op_wr   <= pick_b ? wr_b : wr_a;
                        addr_q  <= pick_b ? addrFromCacheB : addrFromCacheA;
                        wdata_q <= pick_b ? dataFromCacheB : dataFromCacheA;
                        cnt     <= CNT_LOAD;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!op_wr) begin
                        // memRdata has been stable since the strobe cycle (LAT >= 2).
                        if (grant_b) begin
                            dataToCacheB <= memRdata;
                        end else begin
                            dataToCacheA <= memRdata;
                        end
                    end
                end
                ST_DONE: begin
                    last_grant <= grant_b;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        memEn          = 1'b0;
        memWe          = 1'b0;
        rdEnToCacheA   = 1'b0;
        rdEnToCacheB   = 1'b0;
        wbDoneToCacheA = 1'b0;
        wbDoneToCacheB = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // The counter still holds its load value only in the first ACCESS cycle.
                memEn = (cnt == CNT_LOAD);
                memWe = (cnt == CNT_LOAD) && op_wr;
                if (cnt == 4'd0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                rdEnToCacheA   = !grant_b && !op_wr;
                rdEnToCacheB   =  grant_b && !op_wr;
                wbDoneToCacheA = !grant_b &&  op_wr;
                wbDoneToCacheB =  grant_b &&  op_wr;
                state_nxt      = ST_HOLD;
            end
            ST_HOLD: begin
                if (!(grant_b ? req_b : req_a)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign memAddr  = addr_q;
    assign memWdata = wdata_q;
    assign grantB   = grant_b;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int RW_W   = 2;
    localparam int LAT    = 3;

    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_RD   = 2'b01;
    localparam logic [1:0] RW_WR   = 2'b10;
    localparam logic [1:0] RW_INV  = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [RW_W-1:0]   rwFromCacheA = '0, rwFromCacheB = '0;
    logic [ADDR_W-1:0] addrFromCacheA = '0, addrFromCacheB = '0;
    logic [DATA_W-1:0] dataFromCacheA = '0, dataFromCacheB = '0;
    logic [DATA_W-1:0] dataToCacheA, dataToCacheB;
    logic              rdEnToCacheA, rdEnToCacheB, wbDoneToCacheA, wbDoneToCacheB;
    logic              memEn, memWe, grantB;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata = '0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem       [0:255];
    logic [15:0] model_mem [0:255];
    logic [15:0] last_rd   [0:1];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RW_W(RW_W), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .rwFromCacheA(rwFromCacheA), .rwFromCacheB(rwFromCacheB),
        .addrFromCacheA(addrFromCacheA), .addrFromCacheB(addrFromCacheB),
        .dataFromCacheA(dataFromCacheA), .dataFromCacheB(dataFromCacheB),
        .dataToCacheA(dataToCacheA), .dataToCacheB(dataToCacheB),
        .rdEnToCacheA(rdEnToCacheA), .rdEnToCacheB(rdEnToCacheB),
        .wbDoneToCacheA(wbDoneToCacheA), .wbDoneToCacheB(wbDoneToCacheB),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .grantB(grantB)
    );

    always #5 clk = ~clk;

    // Single-ported synchronous memory; read data held until the next strobe.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (memEn) begin
            if (memWe) mem[memAddr[7:0]] <= memWdata;
            else       memRdata <= mem[memAddr[7:0]];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic set_req(input bit port, input logic [1:0] rw, input logic [15:0] a, input logic [15:0] d);
        if (port) begin
            rwFromCacheB = rw; addrFromCacheB = a; dataFromCacheB = d;
        end else begin
            rwFromCacheA = rw; addrFromCacheA = a; dataFromCacheA = d;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(0, RW_IDLE, 16'h0, 16'h0);
        set_req(1, RW_IDLE, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input bit port, output int n);
        bit got;
        got = 1'b0; n = -1;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge clk);
            if (port ? (rdEnToCacheB | wbDoneToCacheB) : (rdEnToCacheA | wbDoneToCacheA)) begin
                got = 1'b1; n = i;
            end
        end
    endtask

    task automatic wait_any(output int n, output bit who);
        bit got;
        got = 1'b0; n = -1; who = 1'b0;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge clk);
            if (rdEnToCacheA | wbDoneToCacheA) begin
                got = 1'b1; n = i; who = 1'b0;
            end else if (rdEnToCacheB | wbDoneToCacheB) begin
                got = 1'b1; n = i; who = 1'b1;
            end
        end
    endtask

    task automatic serve_single(input bit port, input logic [1:0] rw, input logic [15:0] a,
                                input logic [15:0] d, output int n);
        set_req(port, rw, a, d);
        wait_pulse(port, n);
        set_req(port, RW_IDLE, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic serve_tie(input logic [1:0] rwa, input logic [1:0] rwb,
                             output bit first_b, output int n1, output int n2);
        set_req(0, rwa, 16'h0010, 16'hA0A0);
        set_req(1, rwb, 16'h0011, 16'hB0B0);
        wait_any(n1, first_b);
        set_req(first_b, RW_IDLE, 16'h0, 16'h0);
        wait_pulse(!first_b, n2);
        set_req(!first_b, RW_IDLE, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(0, RW_RD, 16'h0042, 16'h1111);
        set_req(1, RW_WR, 16'h0043, 16'h2222);
        repeat (3) @(negedge clk);
        checks++;
        if ({memEn, memWe, rdEnToCacheA, rdEnToCacheB, wbDoneToCacheA, wbDoneToCacheB, grantB} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {memEn, memWe, rdEnToCacheA, rdEnToCacheB, wbDoneToCacheA, wbDoneToCacheB, grantB});
        end
        checks++;
        if (memAddr !== 16'h0 || memWdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0 0", memAddr, memWdata);
        end
        checks++;
        if (dataToCacheA !== 16'h0 || dataToCacheB !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got A %h B %h expected 0 0", dataToCacheA, dataToCacheB);
        end
        set_req(0, RW_IDLE, 16'h0, 16'h0);
        set_req(1, RW_IDLE, 16'h0, 16'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (memEn !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: memEn got %b expected 0", memEn);
        end
    endtask

    task automatic test_single_read();
        logic [15:0] b_data;
        logic        exp;
        preload(8'd5, 16'h00AB);
        b_data = dataToCacheB;
        set_req(0, RW_RD, 16'h0005, 16'h1234);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            exp = (k == LAT + 1);
            checks++;
            if (rdEnToCacheA !== exp) begin
                errors++;
                $display("FAIL single_rd_pulse k=%0d: got %b expected %b", k, rdEnToCacheA, exp);
            end
            exp = (k == 1);
            checks++;
            if (memEn !== exp || memWe !== 1'b0) begin
                errors++;
                $display("FAIL single_rd_strobe k=%0d: got en %b we %b expected en %b we 0", k, memEn, memWe, exp);
            end
            if (k <= LAT) begin
                checks++;
                if (memAddr !== 16'h0005) begin
                    errors++;
                    $display("FAIL single_rd_addr k=%0d: got %h expected 0005", k, memAddr);
                end
            end
            checks++;
            if ({rdEnToCacheB, wbDoneToCacheB, wbDoneToCacheA} !== 3'b000) begin
                errors++;
                $display("FAIL single_rd_other_pulses k=%0d: got %b expected 000", k,
                         {rdEnToCacheB, wbDoneToCacheB, wbDoneToCacheA});
            end
            if (k == 1) addrFromCacheA = 16'h0077;
            if (k == LAT + 1) begin
                checks++;
                if (dataToCacheA !== 16'h00AB) begin
                    errors++;
                    $display("FAIL single_rd_data: got %h expected 00ab", dataToCacheA);
                end
                set_req(0, RW_IDLE, 16'h0, 16'h0);
            end
        end
        checks++;
        if (dataToCacheB !== b_data) begin
            errors++;
            $display("FAIL single_rd_b_data: got %h expected %h", dataToCacheB, b_data);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int n;
        set_req(0, RW_WR, 16'h0000, 16'h0003);
        wait_pulse(0, n);
        checks++;
        if (n != LAT + 1 || wbDoneToCacheA !== 1'b1 || rdEnToCacheA !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: got latency %0d wb %b rd %b expected %0d 1 0", n, wbDoneToCacheA, rdEnToCacheA, LAT + 1);
        end
        checks++;
        if (dataToCacheA !== 16'h00AB) begin
            errors++;
            $display("FAIL wr_keeps_rd_data: got %h expected 00ab", dataToCacheA);
        end
        set_req(0, RW_IDLE, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (mem[0] !== 16'h0003) begin
            errors++;
            $display("FAIL wr_mem: got %h expected 0003", mem[0]);
        end
        set_req(1, RW_RD, 16'h0000, 16'hFFFF);
        wait_pulse(1, n);
        checks++;
        if (n != LAT + 1 || rdEnToCacheB !== 1'b1 || dataToCacheB !== 16'h0003) begin
            errors++;
            $display("FAIL rd_after_wr: got latency %0d rd %b data %h expected %0d 1 0003", n, rdEnToCacheB, dataToCacheB, LAT + 1);
        end
        set_req(1, RW_IDLE, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        preload(8'd1, 16'h0011);
        preload(8'd2, 16'h0022);
        set_req(0, RW_RD, 16'h0001, 16'h0);
        set_req(1, RW_RD, 16'h0002, 16'h0);
        wait_pulse(0, n);
        checks++;
        if (n != LAT + 1 || grantB !== 1'b0 || dataToCacheA !== 16'h0011) begin
            errors++;
            $display("FAIL tie_first_a: got latency %0d grantB %b data %h expected %0d 0 0011", n, grantB, dataToCacheA, LAT + 1);
        end
        set_req(0, RW_IDLE, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        // A asks again just as B, still pending, is about to be served: B wins.
        set_req(0, RW_RD, 16'h0001, 16'h0);
        wait_pulse(1, n);
        checks++;
        if (n != LAT + 1 || grantB !== 1'b1 || dataToCacheB !== 16'h0022) begin
            errors++;
            $display("FAIL tie_second_b: got latency %0d grantB %b data %h expected %0d 1 0022", n, grantB, dataToCacheB, LAT + 1);
        end
        set_req(1, RW_IDLE, 16'h0, 16'h0);
        wait_pulse(0, n);
        checks++;
        if (n != LAT + 3 || grantB !== 1'b0) begin
            errors++;
            $display("FAIL tie_then_a: got latency %0d grantB %b expected %0d 0", n, grantB, LAT + 3);
        end
        set_req(0, RW_IDLE, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_priority();
        int  n, n1, n2;
        bit  first_b;
        bit  exp_b;
        do_reset();
        serve_single(0, RW_RD, 16'h0010, 16'h0, n);
        serve_tie(RW_RD, RW_WR, first_b, n1, n2);
        checks++;
        if (first_b !== 1'b1 || n1 != LAT + 1 || n2 != LAT + 3) begin
            errors++;
            $display("FAIL prio_after_a: got first_b %b lat %0d/%0d expected 1 %0d/%0d", first_b, n1, n2, LAT + 1, LAT + 3);
        end
        serve_single(1, RW_RD, 16'h0011, 16'h0, n);
`ifdef MEMARB_WRITE_PRIORITY_EN
        exp_b = 1'b1;
`else
        exp_b = 1'b0;
`endif
        serve_tie(RW_RD, RW_WR, first_b, n1, n2);
        checks++;
        if (first_b !== exp_b || n1 != LAT + 1) begin
            errors++;
            $display("FAIL prio_after_b: got first_b %b lat %0d expected %b %0d", first_b, n1, exp_b, LAT + 1);
        end
        // Equal-kind tie: the port not served last wins.
        serve_tie(RW_WR, RW_WR, first_b, n1, n2);
        checks++;
        if (first_b !== exp_b) begin
            errors++;
            $display("FAIL prio_equal_kind: got first_b %b expected %b", first_b, exp_b);
        end
    endtask

    task automatic test_hold();
        int n;
        set_req(0, RW_RD, 16'h0005, 16'h0);
        wait_pulse(0, n);
        set_req(1, RW_RD, 16'h0000, 16'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (memEn !== 1'b0 || rdEnToCacheA !== 1'b0 || rdEnToCacheB !== 1'b0) begin
                errors++;
                $display("FAIL hold_quiet k=%0d: got en %b rdA %b rdB %b expected 0 0 0", k, memEn, rdEnToCacheA, rdEnToCacheB);
            end
        end
        set_req(0, RW_IDLE, 16'h0, 16'h0);
        wait_pulse(1, n);
        checks++;
        if (n != LAT + 2 || dataToCacheB !== 16'h0003) begin
            errors++;
            $display("FAIL hold_pending_b: got latency %0d data %h expected %0d 0003", n, dataToCacheB, LAT + 2);
        end
        set_req(1, RW_IDLE, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_req(0, RW_WR, 16'h0009, 16'h5A5A);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        set_req(0, RW_IDLE, 16'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({memEn, memWe, rdEnToCacheA, rdEnToCacheB, wbDoneToCacheA, wbDoneToCacheB, grantB} !== 7'b0 ||
            memAddr !== 16'h0 || memWdata !== 16'h0 || dataToCacheA !== 16'h0 || dataToCacheB !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got ctrl %b addr %h wdata %h dA %h dB %h expected all 0",
                     {memEn, memWe, rdEnToCacheA, rdEnToCacheB, wbDoneToCacheA, wbDoneToCacheB, grantB},
                     memAddr, memWdata, dataToCacheA, dataToCacheB);
        end
        reset = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            checks++;
            if (wbDoneToCacheA !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_ack k=%0d: got %b expected 0", k, wbDoneToCacheA);
            end
        end
        checks++;
        if (mem[9] !== 16'h5A5A) begin
            errors++;
            $display("FAIL reset_mid_mem: got %h expected 5a5a", mem[9]);
        end
    endtask

    task automatic port_agent(input bit port);
        int          n, gap;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [15:0] d;
        logic        rd, wb;
        for (int i = 0; i < 15; i++) begin
            gap = $urandom_range(1, 4);
            repeat (gap) begin
                set_req(port, ($urandom_range(0, 1) == 1) ? RW_INV : RW_IDLE, 16'($urandom), 16'($urandom));
                @(negedge clk);
            end
            op = ($urandom_range(0, 1) == 1) ? RW_WR : RW_RD;
            a  = 8'($urandom_range(0, 7));
            d  = 16'($urandom);
            set_req(port, op, {8'h00, a}, d);
            wait_pulse(port, n);
            rd = port ? rdEnToCacheB : rdEnToCacheA;
            wb = port ? wbDoneToCacheB : wbDoneToCacheA;
            checks++;
            if (n < 0) begin
                errors++;
                $display("FAIL rand_timeout port %0d op %0d: no completion within 200 cycles", port, i);
            end else begin
                if (op == RW_RD) last_rd[port] = model_mem[a];
                else             model_mem[a] = d;
                if ({rd, wb} !== ((op == RW_RD) ? 2'b10 : 2'b01) ||
                    (port ? dataToCacheB : dataToCacheA) !== last_rd[port]) begin
                    errors++;
                    $display("FAIL rand_result port %0d op %0d: got rd %b wb %b data %h expected op %b data %h",
                             port, i, rd, wb, port ? dataToCacheB : dataToCacheA, op, last_rd[port]);
                end
            end
            set_req(port, RW_IDLE, 16'h0, 16'h0);
            @(negedge clk);
            checks++;
            if ((port ? (rdEnToCacheB | wbDoneToCacheB) : (rdEnToCacheA | wbDoneToCacheA)) !== 1'b0) begin
                errors++;
                $display("FAIL rand_pulse_width port %0d op %0d: pulse still high, expected 0", port, i);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        for (int i = 0; i < 8; i++) preload(8'(i), 16'($urandom));
        fork
            port_agent(0);
            port_agent(1);
        join
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== model_mem[i]) begin
                errors++;
                $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem[i], model_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_tie();
        test_write_priority();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
